fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, one-entry skid buffer and branch redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic [6:0]  opcode,
    output logic [2:0]  funct_three,
    output logic [4:0]  funct_five
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        accept;
    logic        load_mem;
    logic        load_skid;
    logic        fill_skid;
    logic        pc_step;

    // Decode may take a new IF/ID entry when the current one is empty or being consumed
    assign accept    = !valid_out || !stall;
    assign imem_addr = pc;

    // Field views of the IF/ID word; they change exactly when instr does
    assign opcode      = instr[6:0];
    assign funct_three = instr[14:12];
    assign funct_five  = instr[31:27];

    // Next-state and datapath strobes; a redirect overrides everything else
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        load_mem   = 1'b0;
        load_skid  = 1'b0;
        fill_skid  = 1'b0;
        pc_step    = 1'b0;
        if (state == ISSUE) begin
            imem_req = 1'b1;
        end
        if (branch_taken) begin
            // Only an unanswered request in WAIT leaves a response in flight to discard
            next_state = (state == WAIT && !imem_valid) ? DROP : ISSUE;
        end else begin
            case (state)
                IDLE:  next_state = ISSUE;
                ISSUE: next_state = WAIT;
                WAIT: begin
                    if (imem_valid) begin
                        pc_step = 1'b1;
                        if (accept) begin
                            load_mem   = 1'b1;
                            next_state = ISSUE;
                        end else begin
                            fill_skid  = 1'b1;
                            next_state = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        load_skid  = 1'b1;
                        next_state = ISSUE;
                    end
                end
                DROP: begin
                    if (imem_valid) begin
                        next_state = ISSUE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fetch PC: redirect or advance by one word once a response has been taken
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC & 32'hFFFF_FFFC;
        end else if (branch_taken) begin
            pc <= branch_target & 32'hFFFF_FFFC;
        end else if (pc_step) begin
            pc <= pc + 32'd4;
        end
    end

    // Skid entry; it is live exactly while the FSM sits in HOLD, so leaving HOLD empties it
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
        end else if (fill_skid) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
        end
    end

    // IF/ID register: held under stall, cleared on redirect or when drained with nothing behind it
    always_ff @(posedge clk) begin
        if (rst) begin
            instr     <= 32'h0;
            pc_out    <= 32'h0;
            valid_out <= 1'b0;
        end else if (branch_taken) begin
            valid_out <= 1'b0;
        end else if (load_mem) begin
            instr     <= imem_rdata;
            pc_out    <= pc;
            valid_out <= 1'b1;
        end else if (load_skid) begin
            instr     <= skid_instr;
            pc_out    <= skid_pc;
            valid_out <= 1'b1;
        end else if (accept) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [6:0]  opcode;
    logic [2:0]  funct_three;
    logic [4:0]  funct_five;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .instr(instr),
        .pc_out(pc_out),
        .valid_out(valid_out),
        .opcode(opcode),
        .funct_three(funct_three),
        .funct_five(funct_five)
    );

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [63:0] sb_q[$];
    logic        out_pend;
    int          out_cnt;
    logic        out_killed;
    logic [31:0] out_addr;
    logic [31:0] exp_addr;
    int          lat;
    logic        prev_hold;
    logic        prev_br;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc_out;
    int          consumed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h4020_8033;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Called at a falling edge with this cycle's rst/stall/branch already set
    task automatic cycle();
        logic [63:0] e;
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (prev_hold) begin
            check_eq("hold_instr", instr, prev_instr);
            check_eq("hold_pc_out", pc_out, prev_pc_out);
        end
        if (prev_br) check_eq("branch_clears_valid", valid_out, 1'b0);
        prev_hold   = valid_out && stall && !branch_taken && !rst;
        prev_br     = branch_taken;
        prev_instr  = instr;
        prev_pc_out = pc_out;
        if (rst) begin
            out_pend = 1'b0;
            sb_q.delete();
            exp_addr = RESET_PC;
        end else begin
            if (valid_out && !stall && !branch_taken) begin
                check_eq("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("pc_out", pc_out, e[63:32]);
                    check_eq("instr", instr, e[31:0]);
                    check_eq("opcode", {25'h0, opcode}, {25'h0, e[6:0]});
                    check_eq("funct_three", {29'h0, funct_three}, {29'h0, e[14:12]});
                    check_eq("funct_five", {27'h0, funct_five}, {27'h0, e[31:27]});
                end
                consumed++;
            end
            if (out_pend) begin
                out_cnt--;
                if (out_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(out_addr);
                    out_pend   = 1'b0;
                    if (!out_killed && !branch_taken) sb_q.push_back({out_addr, imem_rdata});
                end
            end
            if (branch_taken) begin
                sb_q.delete();
                if (out_pend) out_killed = 1'b1;
            end
            if (imem_req) begin
                check_eq("one_outstanding", out_pend, 1'b0);
                check_eq("imem_addr", imem_addr, exp_addr);
                exp_addr   = exp_addr + 32'd4;
                out_pend   = 1'b1;
                out_cnt    = lat;
                out_killed = 1'b0;
                out_addr   = imem_addr;
            end
            if (branch_taken) exp_addr = branch_target & 32'hFFFF_FFFC;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, imem_req, 1'b0);
        check_eq({tag, "_instr"}, instr, 32'h0);
        check_eq({tag, "_pc_out"}, pc_out, 32'h0);
        check_eq({tag, "_valid"}, valid_out, 1'b0);
        check_eq({tag, "_opcode"}, {25'h0, opcode}, 32'h0);
        check_eq({tag, "_f3"}, {29'h0, funct_three}, 32'h0);
        check_eq({tag, "_f5"}, {27'h0, funct_five}, 32'h0);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!valid_out && k < 30) begin
            cycle();
            k++;
        end
        check_eq({tag, "_wait_valid"}, k < 30, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_valid = 1'b0; imem_rdata = 32'h0;
        out_pend = 1'b0; out_cnt = 0; out_killed = 1'b0; out_addr = 32'h0;
        exp_addr = RESET_PC; lat = 1; prev_hold = 1'b0; prev_br = 1'b0;
        prev_instr = 32'h0; prev_pc_out = 32'h0; consumed = 0;
        @(negedge clk);
        repeat (3) cycle();
        check_reset_outputs("reset");
        rst = 1'b0;
        cycle();
        check_eq("first_req", imem_req, 1'b1);
        check_eq("first_addr", imem_addr, RESET_PC);

        // First fetch through a one-cycle memory
        wait_valid("first_fetch");
        check_eq("first_instr", instr, 32'h0050_0093);
        check_eq("first_opcode", {25'h0, opcode}, 32'h13);
        check_eq("first_pc_out", pc_out, 32'h0);
        check_eq("first_valid", valid_out, 1'b1);
        check_eq("second_req", imem_req, 1'b1);
        check_eq("second_addr", imem_addr, 32'h4);

        // Response arrives under stall: held in the skid entry, no new request
        stall = 1'b1;
        cycle();
        cycle();
        repeat (3) begin
            check_eq("hold_no_req", imem_req, 1'b0);
            check_eq("hold_if_id", instr, 32'h0050_0093);
            cycle();
        end
        stall = 1'b0;
        cycle();
        check_eq("skid_instr", instr, 32'h4020_8033);
        check_eq("skid_funct_five", {27'h0, funct_five}, 32'h8);
        check_eq("skid_valid", valid_out, 1'b1);

        // Redirect in WAIT, response two cycles later must be dropped
        lat = 3;
        cycle();
        branch_taken = 1'b1; branch_target = 32'h0000_0102;
        cycle();
        branch_taken = 1'b0;
        k = 0;
        while (!imem_req && k < 10) begin
            cycle();
            k++;
        end
        check_eq("drop_timeout", k < 10, 1'b1);
        check_eq("drop_valid", valid_out, 1'b0);
        check_eq("drop_target_addr", imem_addr, 32'h0000_0100);

        // Redirect coinciding with a response under stall
        lat = 2;
        wait_valid("coincide");
        stall = 1'b1;
        cycle();
        cycle();
        check_eq("coincide_due", out_pend && out_cnt == 1, 1'b1);
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        cycle();
        branch_taken = 1'b0;
        check_eq("coincide_valid", valid_out, 1'b0);
        check_eq("coincide_req", imem_req, 1'b1);
        check_eq("coincide_addr", imem_addr, 32'h0000_0200);
        stall = 1'b0;

        // PC wraps at the top of the address space; target low bits are ignored
        lat = 1;
        cycle();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        cycle();
        branch_taken = 1'b0;
        wait_valid("wrap");
        check_eq("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        check_eq("wrap_instr", instr, mem_word(32'hFFFF_FFFC));
        check_eq("wrap_req", imem_req, 1'b1);
        check_eq("wrap_next_addr", imem_addr, 32'h0);

        // Random stall, latency and redirects
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            lat   = $urandom_range(1, 3);
            branch_taken = 1'b0;
            if (!imem_req && !(out_pend && out_killed) && $urandom_range(0, 19) == 0) begin
                branch_taken  = 1'b1;
                branch_target = $urandom;
            end
            cycle();
        end
        branch_taken = 1'b0;
        stall = 1'b0;
        check_eq("progress", consumed > 40, 1'b1);
        check_eq("sb_depth", sb_q.size() <= 2, 1'b1);

        // Reset while dropping a response
        lat = 3;
        k = 0;
        while (!(out_pend && !out_killed && out_cnt >= 2) && k < 20) begin
            cycle();
            k++;
        end
        check_eq("reach_wait_timeout", k < 20, 1'b1);
        branch_taken = 1'b1; branch_target = 32'h0000_0400;
        cycle();
        branch_taken = 1'b0;
        rst = 1'b1;
        cycle();
        check_reset_outputs("drop_reset");
        rst = 1'b0;
        lat = 1;
        cycle();
        check_eq("restart_req", imem_req, 1'b1);
        check_eq("restart_addr", imem_addr, RESET_PC);
        wait_valid("restart");
        check_eq("restart_instr", instr, 32'h0050_0093);
        check_eq("restart_pc_out", pc_out, RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
